// File: rtl/mtx_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mtx_serializer_pkg
// Brief   : Shared constants and FSM state type for the 2x2 complex matrix
//           serializer / decoder pair.
// Revision: 1.0 - initial release
// ============================================================================
package mtx_serializer_pkg;

  localparam int MTX_WIDTH = 19;
  localparam int MTX_ELEMS = 8;
  localparam int MTX_IDX_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } mtx_state_e;

endpackage
`default_nettype wire

// File: rtl/mtx_serializer.sv
`default_nettype none
// ============================================================================
// Module  : mtx_serializer
// Brief   : Captures a 2x2 complex matrix on start and streams its 8 signed
//           components out one per accepted valid/ready beat.
// Revision: 1.0 - initial release
// ============================================================================
module mtx_serializer
  import mtx_serializer_pkg::*;
#(
  parameter int WIDTH = MTX_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] matrix_in [0:1][0:1][0:1],
  input  logic                    start,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] matrix_out,
  output logic                    imag,
  output logic                    row,
  output logic                    col,
  output logic                    out_valid,
  output logic                    busy,
  output logic                    done
);

  localparam logic [MTX_IDX_W-1:0] LAST_IDX = MTX_IDX_W'(MTX_ELEMS - 1);

  mtx_state_e             state_q, state_d;
  logic [MTX_IDX_W-1:0]   idx_q, idx_d;
  logic signed [WIDTH-1:0] bank_q [0:1][0:1][0:1];
  logic                   load;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          load    = 1'b1;
          idx_d   = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (out_ready) begin
          // Index stops at the last element; leaving SEND ends the stream.
          if (idx_q == LAST_IDX) state_d = ST_DONE;
          else                   idx_d   = idx_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)     bank_q <= '{default: '0};
    else if (load) bank_q <= matrix_in;
  end

  // Element index is {row,col,imag}, so the bank is addressed by its bits.
  assign matrix_out = bank_q[idx_q[2]][idx_q[1]][idx_q[0]];
  assign row        = idx_q[2];
  assign col        = idx_q[1];
  assign imag       = idx_q[0];
  assign out_valid  = (state_q == ST_SEND);
  assign busy       = (state_q == ST_SEND);
  assign done       = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: doc/mtx_serializer.md
MTX_SERIALIZER -- requirements
Module: mtx_serializer

Interface
REQ-001 SHALL have parameter: WIDTH, default 19, signed bit width of one real or imaginary matrix component.
REQ-002 SHALL have port: clk  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: matrix_in  input  signed [WIDTH-1:0] [0:1][0:1][0:1]  2x2 complex result to send, indexed [row][col][imag].
REQ-005 SHALL have port: start  input  1  single-cycle request to capture matrix_in and begin transmission.
REQ-006 SHALL have port: out_ready  input  1  downstream accepts the current element this cycle.
REQ-007 SHALL have port: matrix_out  output  signed [WIDTH-1:0]  current element value.
REQ-008 SHALL have port: imag  output  1  high if matrix_out is the imaginary part, low if real.
REQ-009 SHALL have port: row  output  1  row index of matrix_out.
REQ-010 SHALL have port: col  output  1  column index of matrix_out.
REQ-011 SHALL have port: out_valid  output  1  matrix_out/imag/row/col hold a valid element.
REQ-012 SHALL have port: busy  output  1  high while a capture is being transmitted (SEND state).
REQ-013 SHALL have port: done  output  1  one-cycle pulse after the last element is accepted.

Function
REQ-014 SHALL implement states IDLE, SEND, DONE.
REQ-015 In IDLE or DONE, start=1 SHALL copy all 8 elements of matrix_in into an internal register bank, clear the 3-bit element index to 0 and enter SEND on the next edge.
REQ-016 start SHALL be ignored in SEND; the captured bank SHALL NOT change until the next accepted start.
REQ-017 Element index SHALL be {row,col,imag}: order is (0,0,re),(0,0,im),(0,1,re),(0,1,im),(1,0,re),(1,0,im),(1,1,re),(1,1,im).
REQ-018 In SEND, out_valid SHALL be 1 and matrix_out/row/col/imag SHALL present the captured element at the current index; out_valid SHALL be 0 in IDLE and DONE.
REQ-019 Latency: start sampled at edge N SHALL give out_valid=1 with element 0 in the cycle after edge N.
REQ-020 A transfer SHALL occur when out_valid && out_ready at a rising edge; only then SHALL the index increment.
REQ-021 While out_valid && !out_ready, matrix_out, row, col and imag SHALL hold stable.
REQ-022 A transfer at index 7 SHALL move to DONE; done SHALL be 1 for exactly that one cycle, then the FSM SHALL return to IDLE unless start=1 in the DONE cycle (REQ-015).
REQ-023 The index SHALL NOT wrap: after index 7 the FSM leaves SEND.
REQ-024 Values SHALL pass through unmodified (no rounding, saturation or sign change).
REQ-025 With out_ready held high, one capture SHALL take exactly 8 SEND cycles plus 1 DONE cycle.

Reset
REQ-026 reset=1 at an edge SHALL force IDLE, index=0, out_valid=0, busy=0, done=0, matrix_out=0, row=col=imag=0, register bank=0; reset SHALL take priority over start.
REQ-027 Reset during SEND SHALL abort the transfer with no done pulse.

Structure
REQ-028 A shared package SHALL hold the WIDTH default (19), element count (8), index width (3) and the state enum; mtx_decoder and this block SHALL use the same package.
REQ-029 No sub-module is required; the module SHALL be a single FSM plus register bank and index counter.
REQ-030 The module SHALL connect directly to the complex_matrix_multiplier result and done outputs (done -> start).

Verification
REQ-031 Reset then matrix {r00=1,i00=-1,r01=2,i01=-2,r10=3,i10=-3,r11=4,i11=-4}, start, out_ready=1 -> outputs 1,-1,2,-2,3,-3,4,-4 on consecutive cycles with the matching row/col/imag, then done=1 for one cycle.
REQ-032 Same load, out_ready toggling 1,0,1,0 -> each element held through the stalled cycles; done after the 8th accepted beat (16 cycles).
REQ-033 start pulsed mid-SEND with a different matrix -> ignored; the original 8 values are sent.
REQ-034 reset asserted after 3 transfers -> next cycle out_valid=0, busy=0, no done; a new start sends from element 0.
REQ-035 start asserted in the DONE cycle -> done=1 and the next cycle out_valid=1 with the new element 0.
REQ-036 Extremes -262144 and +262143 loaded -> emitted bit-exact.
